// File: rtl/toggle_flip_flop_array_pkg.sv
// ---------------------------------------------------------------------------
// toggle_flip_flop_array_pkg : shared action encoding and priority resolver
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package toggle_flip_flop_array_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    TOGGLE = 2'd1,
    SET    = 2'd2,
    CLEAR  = 2'd3
  } channel_action_t;

  localparam int DEFAULT_COUNT_WIDTH = 16;

  // Clear dominates set, and either of them masks a toggle request.
  function automatic channel_action_t resolve_action(input logic clear,
                                                     input logic set,
                                                     input logic toggle);
    channel_action_t act;
    if (clear)       act = CLEAR;
    else if (set)    act = SET;
    else if (toggle) act = TOGGLE;
    else             act = HOLD;
    return act;
  endfunction

endpackage

`default_nettype wire

// File: rtl/toggle_flip_flop_array_channel.sv
// ---------------------------------------------------------------------------
// toggle_flip_flop_array_channel : one toggle cell with set/clear and change flag
// Revision: 1.0   (TOGGLE_FLIP_FLOP_ARRAY_COUNTER_EN exposes the next change flag)
// ---------------------------------------------------------------------------
`default_nettype none

module toggle_flip_flop_array_channel
  import toggle_flip_flop_array_pkg::*;
#(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic toggle_i,
  input  logic set_i,
  input  logic clear_i,
`ifdef TOGGLE_FLIP_FLOP_ARRAY_COUNTER_EN
  output logic changed_next_o,
`endif
  output logic state_o,
  output logic changed_o
);

  logic state_q, state_d;
  logic changed_q, changed_d;

  always_comb begin
    state_d = state_q;
    if (enable_i) begin
      case (resolve_action(clear_i, set_i, toggle_i))
        CLEAR:   state_d = 1'b0;
        SET:     state_d = 1'b1;
        TOGGLE:  state_d = ~state_q;
        default: state_d = state_q;
      endcase
    end
    changed_d = state_d ^ state_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RESET_VALUE;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      changed_q <= changed_d;
    end
  end

  assign state_o   = state_q;
  assign changed_o = changed_q;
`ifdef TOGGLE_FLIP_FLOP_ARRAY_COUNTER_EN
  assign changed_next_o = changed_d;
`endif

endmodule

`default_nettype wire

// File: rtl/toggle_flip_flop_array.sv
// ---------------------------------------------------------------------------
// toggle_flip_flop_array : WIDTH toggle cells, parity, optional change counter
// Revision: 1.0   (TOGGLE_FLIP_FLOP_ARRAY_COUNTER_EN adds toggle_count/count_clear)
// ---------------------------------------------------------------------------
`default_nettype none

module toggle_flip_flop_array
  import toggle_flip_flop_array_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
`ifdef TOGGLE_FLIP_FLOP_ARRAY_COUNTER_EN
  ,
  parameter int               COUNT_WIDTH = DEFAULT_COUNT_WIDTH
`endif
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic [WIDTH-1:0] toggle,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clear,
`ifdef TOGGLE_FLIP_FLOP_ARRAY_COUNTER_EN
  input  logic                   count_clear,
  output logic [COUNT_WIDTH-1:0] toggle_count,
`endif
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] changed,
  output logic             parity
);

`ifdef TOGGLE_FLIP_FLOP_ARRAY_COUNTER_EN
  logic [WIDTH-1:0] changed_next;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_channel
    toggle_flip_flop_array_channel #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_channel (
      .clk_i          (clock),
      .rst_ni         (resetn),
      .enable_i       (enable),
      .toggle_i       (toggle[i]),
      .set_i          (set[i]),
      .clear_i        (clear[i]),
`ifdef TOGGLE_FLIP_FLOP_ARRAY_COUNTER_EN
      .changed_next_o (changed_next[i]),
`endif
      .state_o        (state[i]),
      .changed_o      (changed[i])
    );
  end

  assign parity = ^state;

`ifdef TOGGLE_FLIP_FLOP_ARRAY_COUNTER_EN
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // Clear is deliberately independent of enable so software can always zero it.
  always_comb begin
    count_d = count_q;
    if (count_clear)
      count_d = '0;
    else if ((|changed_next) && (count_q != {COUNT_WIDTH{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign toggle_count = count_q;
`endif

endmodule

`default_nettype wire
